// File: rtl/fpu_issue_scheduler.sv
// fpu_issue_scheduler: gates FP issue on scoreboard, writeback-slot ring, divider and condition-code state.
module fpu_issue_scheduler #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 10,
    parameter int MOV_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [1:0] issue_class,
    input  logic       issue_double,
    input  logic [4:0] issue_fs,
    input  logic [4:0] issue_ft,
    input  logic [4:0] issue_fd,
    input  logic       issue_uses_ft,
    input  logic       issue_writes_fd,
    input  logic       issue_is_cmp,
    input  logic       bfpc_pending,
    output logic       issue_ready,
    output logic       stall,
    output logic       cc_stall,
    output logic       fpu_start,
    output logic       wb_valid,
    output logic [4:0] wb_fd,
    output logic       wb_double,
    output logic       busy
);
    logic [31:0] sb;
    logic [15:0] ringValid, ringWrites, ringCmp, ringDouble;
    logic [4:0]  ringFd [16];
    logic        ccPending, divBusy;
    logic [3:0]  divCnt, lat;
    logic [4:0]  fs, ft, fd;
    logic [31:0] needMask, setMask, clrMask;

    function automatic logic [31:0] pairMask(input logic [4:0] r, input logic dbl);
        pairMask = (32'd1 << r) | (dbl ? (32'd2 << r) : 32'd0);
    endfunction

    assign fs = issue_double ? {issue_fs[4:1], 1'b0} : issue_fs;
    assign ft = issue_double ? {issue_ft[4:1], 1'b0} : issue_ft;
    assign fd = issue_double ? {issue_fd[4:1], 1'b0} : issue_fd;
    assign lat = issue_class == 2'd0 ? 4'(ADD_LAT) :
                 issue_class == 2'd1 ? 4'(MUL_LAT) :
                 issue_class == 2'd2 ? 4'(DIV_LAT) : 4'(MOV_LAT);

    assign needMask = pairMask(fs, issue_double)
                    | (issue_uses_ft ? pairMask(ft, issue_double) : 32'd0)
                    | (issue_writes_fd ? pairMask(fd, issue_double) : 32'd0);
    assign setMask = issue_writes_fd ? pairMask(fd, issue_double) : 32'd0;
    assign clrMask = (ringValid[0] & ringWrites[0]) ? pairMask(ringFd[0], ringDouble[0]) : 32'd0;

    // Slot lat is the one that shifts into lat-1 at the edge, so it must be free now.
    assign issue_ready = issue_valid & ~reset & ~|(sb & needMask) & ~ringValid[lat]
                       & ~((issue_class == 2'd2) & divBusy) & ~(issue_is_cmp & ccPending);
    assign fpu_start = issue_valid & issue_ready;
    assign cc_stall  = bfpc_pending & ccPending;
    assign stall     = (issue_valid & ~issue_ready) | cc_stall;
    assign wb_valid  = ringValid[0] & (ringWrites[0] | ringCmp[0]);
    assign wb_fd     = wb_valid ? ringFd[0] : 5'd0;
    assign wb_double = wb_valid & ringDouble[0];
    assign busy      = |ringValid;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb <= '0;
            ringValid <= '0;
            ringWrites <= '0;
            ringCmp <= '0;
            ringDouble <= '0;
            for (int k = 0; k < 16; k++) ringFd[k] <= '0;
            ccPending <= 1'b0;
            divBusy <= 1'b0;
            divCnt <= '0;
        end else begin
            sb <= (sb & ~clrMask) | (fpu_start ? setMask : 32'd0);
            for (int k = 0; k < 15; k++) begin
                ringValid[k] <= ringValid[k+1];
                ringWrites[k] <= ringWrites[k+1];
                ringCmp[k] <= ringCmp[k+1];
                ringDouble[k] <= ringDouble[k+1];
                ringFd[k] <= ringFd[k+1];
            end
            ringValid[15] <= 1'b0;
            ringWrites[15] <= 1'b0;
            ringCmp[15] <= 1'b0;
            ringDouble[15] <= 1'b0;
            ringFd[15] <= '0;
            if (fpu_start) begin
                ringValid[lat-1] <= 1'b1;
                ringWrites[lat-1] <= issue_writes_fd;
                ringCmp[lat-1] <= issue_is_cmp;
                ringDouble[lat-1] <= issue_double;
                ringFd[lat-1] <= fd;
            end
            ccPending <= (fpu_start & issue_is_cmp) ? 1'b1 : (ringValid[0] & ringCmp[0]) ? 1'b0 : ccPending;
            if (fpu_start && issue_class == 2'd2) begin
                divBusy <= 1'b1;
                divCnt <= 4'(DIV_LAT - 1);
            end else if (divBusy) begin
                divBusy <= divCnt != 4'd0;
                divCnt <= divCnt == 4'd0 ? 4'd0 : divCnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// tb_fpu_issue_scheduler: directed and random checks against an in-flight-op list model.
module tb_fpu_issue_scheduler;
    localparam int ADD = 2, MUL = 4, DIV = 10, MOV = 1;

    logic       clk = 1'b0;
    logic       reset, issue_valid, issue_double, issue_uses_ft, issue_writes_fd, issue_is_cmp, bfpc_pending;
    logic [1:0] issue_class;
    logic [4:0] issue_fs, issue_ft, issue_fd;
    logic       issue_ready, stall, cc_stall, fpu_start, wb_valid, wb_double, busy;
    logic [4:0] wb_fd;

    int checks = 0, errors = 0;

    fpu_issue_scheduler #(.ADD_LAT(ADD), .MUL_LAT(MUL), .DIV_LAT(DIV), .MOV_LAT(MOV)) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_class(issue_class),
        .issue_double(issue_double), .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .issue_uses_ft(issue_uses_ft), .issue_writes_fd(issue_writes_fd), .issue_is_cmp(issue_is_cmp),
        .bfpc_pending(bfpc_pending), .issue_ready(issue_ready), .stall(stall), .cc_stall(cc_stall),
        .fpu_start(fpu_start), .wb_valid(wb_valid), .wb_fd(wb_fd), .wb_double(wb_double), .busy(busy)
    );

    always #5 clk = ~clk;

    // Each in-flight op: absolute retire cycle and the register range it writes.
    typedef struct {int ret; int lo; int hi; bit wr; bit cmp;} op_t;
    op_t q[$];
    int  cyc = 0, lastDiv = -1000;
    bit  started, sawWb, expIssue;
    int  sawFd;

    function automatic int latOf(int c);
        return c == 0 ? ADD : c == 1 ? MUL : c == 2 ? DIV : MOV;
    endfunction

    function automatic int base(logic [4:0] r, logic d);
        return d ? (int'(r) & ~1) : int'(r);
    endfunction

    function automatic bit hits(op_t o, int r, bit d);
        return o.wr && r <= o.hi && r + int'(d) >= o.lo;
    endfunction

    function automatic bit modelReady();
        int L;
        bit d;
        if (!issue_valid || reset) return 0;
        d = issue_double;
        L = latOf(int'(issue_class));
        if (issue_class == 2 && cyc <= lastDiv + DIV) return 0;
        foreach (q[i]) begin
            if (q[i].ret == cyc + L) return 0;
            if (issue_is_cmp && q[i].cmp) return 0;
            if (hits(q[i], base(issue_fs, d), d)) return 0;
            if (issue_uses_ft && hits(q[i], base(issue_ft, d), d)) return 0;
            if (issue_writes_fd && hits(q[i], base(issue_fd, d), d)) return 0;
        end
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called just after a negedge with inputs set; checks this cycle, then advances one edge.
    task automatic tick();
        bit ccp = 0, wv = 0;
        int wf = 0, wd = 0;
        #1;
        expIssue = modelReady();
        foreach (q[i]) begin
            if (q[i].cmp) ccp = 1;
            if (q[i].ret == cyc && (q[i].wr || q[i].cmp)) begin
                wv = 1;
                wf = q[i].lo;
                wd = q[i].hi - q[i].lo;
            end
        end
        check("issue_ready", issue_ready, expIssue);
        check("fpu_start", fpu_start, expIssue);
        check("cc_stall", cc_stall, bfpc_pending & ccp);
        check("stall", stall, (issue_valid & !expIssue) | (bfpc_pending & ccp));
        check("wb_valid", wb_valid, wv);
        check("wb_fd", wb_fd, wf);
        check("wb_double", wb_double, wd);
        check("busy", busy, q.size() != 0);
        started = fpu_start;
        sawWb = wb_valid;
        sawFd = int'(wb_fd);
        @(posedge clk);
        if (reset) begin
            q.delete();
            lastDiv = -1000;
        end else begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].ret <= cyc) q.delete(i);
            if (expIssue) begin
                op_t o;
                o.ret = cyc + latOf(int'(issue_class));
                o.lo = base(issue_fd, issue_double);
                o.hi = o.lo + int'(issue_double);
                o.wr = issue_writes_fd;
                o.cmp = issue_is_cmp;
                q.push_back(o);
                if (issue_class == 2) lastDiv = cyc;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        issue_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents an op and holds it until accepted; w = cycles spent stalled.
    task automatic issueOp(input logic [1:0] c, input logic d, input logic [4:0] fs, ft, fd,
                           input logic uft, wfd, cmp, output int w);
        issue_valid = 1;
        issue_class = c;
        issue_double = d;
        issue_fs = fs;
        issue_ft = ft;
        issue_fd = fd;
        issue_uses_ft = uft;
        issue_writes_fd = wfd;
        issue_is_cmp = cmp;
        w = 0;
        tick();
        while (!started && w < 40) begin
            w++;
            tick();
        end
        check("issue_wait_bound", started, 1);
        issue_valid = 0;
    endtask

    task automatic latency(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sawWb && n < 20);
    endtask

    initial begin
        int w, n;
        reset = 1;
        issue_valid = 1;
        issue_class = 0;
        issue_double = 0;
        issue_fs = 1;
        issue_ft = 3;
        issue_fd = 2;
        issue_uses_ft = 1;
        issue_writes_fd = 1;
        issue_is_cmp = 0;
        bfpc_pending = 0;
        @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        reset = 0;

        issueOp(2'd0, 0, 5'd1, 5'd3, 5'd2, 1, 1, 0, w);
        check("t1_wait", w, 0);
        latency(n);
        check("t1_latency", n, ADD);
        check("t1_wbfd", sawFd, 2);

        idle(4);
        issueOp(2'd0, 0, 5'd6, 5'd7, 5'd2, 1, 1, 0, w);
        issueOp(2'd1, 0, 5'd2, 5'd7, 5'd12, 1, 1, 0, w);
        check("t2_raw_wait", w, 2);
        latency(n);
        check("t2_latency", n, MUL);
        check("t2_wbfd", sawFd, 12);

        idle(4);
        issueOp(2'd2, 1, 5'd0, 5'd2, 5'd4, 1, 1, 0, w);
        issueOp(2'd1, 0, 5'd5, 5'd0, 5'd14, 0, 1, 0, w);
        check("t3_pair_wait", w, DIV);
        idle(6);
        issueOp(2'd2, 0, 5'd16, 5'd17, 5'd20, 1, 1, 0, w);
        issueOp(2'd2, 0, 5'd18, 5'd19, 5'd22, 1, 1, 0, w);
        check("t3_div_wait", w, DIV);

        idle(14);
        issueOp(2'd1, 0, 5'd1, 5'd3, 5'd8, 1, 1, 0, w);
        idle(1);
        issueOp(2'd0, 0, 5'd3, 5'd1, 5'd9, 1, 1, 0, w);
        check("t4_slot_wait", w, 1);
        latency(n);
        check("t4_mul_wbfd", sawFd, 8);
        latency(n);
        check("t4_add_gap", n, 1);
        check("t4_add_wbfd", sawFd, 9);

        idle(4);
        bfpc_pending = 1;
        issueOp(2'd0, 0, 5'd1, 5'd3, 5'd0, 1, 0, 1, w);
        check("t5_cmp_wait", w, 0);
        issueOp(2'd0, 0, 5'd5, 5'd7, 5'd0, 1, 0, 1, w);
        check("t5_cmp2_wait", w, 2);
        idle(4);
        bfpc_pending = 0;

        issueOp(2'd2, 0, 5'd26, 5'd27, 5'd24, 1, 1, 0, w);
        idle(3);
        reset = 1;
        tick();
        reset = 0;
        issueOp(2'd2, 0, 5'd26, 5'd27, 5'd24, 1, 1, 0, w);
        check("t6_div_after_reset", w, 0);
        idle(14);

        for (int i = 0; i < 800; i++) begin
            reset = ($urandom % 90) == 0;
            issue_valid = ($urandom % 4) != 0;
            issue_class = 2'($urandom);
            issue_double = $urandom % 3 == 0;
            issue_fs = 5'($urandom % 8);
            issue_ft = 5'($urandom % 8);
            issue_fd = 5'($urandom % 8);
            issue_uses_ft = 1'($urandom);
            issue_writes_fd = ($urandom % 4) != 0;
            issue_is_cmp = issue_class == 0 && ($urandom % 3) == 0;
            bfpc_pending = ($urandom % 3) == 0;
            tick();
        end
        reset = 0;
        bfpc_pending = 0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
